// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port; zero-latency outputs, one bubble cycle per grant.
// Holds the grant and beat count while fifo_full_i is set; FIFO_ARB_PRIO_EN lets requester 0 win every idle arbitration.
module fifo_wr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4,
   parameter int IDX_WIDTH = 2,
   parameter int CNT_WIDTH = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NUM_REQ-1:0]       req_i,
   input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]       last_i,
   output logic [NUM_REQ-1:0]       gnt_o,
   output logic [WIDTH-1:0]         fifo_wdata_o,
   output logic                     fifo_wr_en_o,
   input  logic                     fifo_full_i,
   output logic                     busy_o,
   output logic [IDX_WIDTH-1:0]     owner_o
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t               state_q, state_d;
   logic [IDX_WIDTH-1:0] owner_q, owner_d;
   logic [IDX_WIDTH-1:0] last_owner_q, last_owner_d;
   logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;

   logic [WIDTH-1:0]     req_data [NUM_REQ];
   logic [IDX_WIDTH-1:0] rr_idx, rr_k, sel_idx;
   logic                 rr_vld, sel_vld;
   logic                 own_req, own_last, accept, at_max;

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
      assign req_data[k] = req_data_i[k*WIDTH +: WIDTH];
   end

   // First requester after the previous owner, wrapping modulo NUM_REQ.
   always_comb begin
      rr_vld = 1'b0;
      rr_idx = '0;
      rr_k   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         rr_k = IDX_WIDTH'((int'(last_owner_q) + i) % NUM_REQ);
         if (!rr_vld && req_i[rr_k]) begin
            rr_vld = 1'b1;
            rr_idx = rr_k;
         end
      end
   end

`ifdef FIFO_ARB_PRIO_EN
   assign sel_vld = rr_vld;
   assign sel_idx = req_i[0] ? '0 : rr_idx;
`else
   assign sel_vld = rr_vld;
   assign sel_idx = rr_idx;
`endif

   assign own_req  = req_i[owner_q];
   assign own_last = last_i[owner_q];
   assign accept   = own_req & ~fifo_full_i;
   assign at_max   = (beat_cnt_q == CNT_WIDTH'(MAX_BURST - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         owner_q      <= '0;
         last_owner_q <= IDX_WIDTH'(NUM_REQ - 1);
         beat_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         beat_cnt_q   <= beat_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      beat_cnt_d   = beat_cnt_q;
      case (state_q)
         IDLE: begin
            if (sel_vld) begin
               state_d    = BUSY;
               owner_d    = sel_idx;
               beat_cnt_d = '0;
            end
         end
         BUSY: begin
            if (!own_req) begin
               state_d      = IDLE;
               last_owner_d = owner_q;
            end else if (accept) begin
               beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
               if (own_last || at_max) begin
                  state_d      = IDLE;
                  last_owner_d = owner_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are forced quiet during reset so a burst cannot write in the reset cycle.
   always_comb begin
      busy_o       = 1'b0;
      fifo_wr_en_o = 1'b0;
      owner_o      = '0;
      gnt_o        = '0;
      if (!rst_i) begin
         busy_o       = (state_q == BUSY);
         fifo_wr_en_o = (state_q == BUSY) & accept;
         owner_o      = owner_q;
         if ((state_q == BUSY) && accept) begin
            gnt_o[owner_q] = 1'b1;
         end
      end
   end

   assign fifo_wdata_o = req_data[owner_q];

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with NUM_REQ=4, WIDTH=8, MAX_BURST=4.
module tb_fifo_wr_arbiter;

   localparam logic [31:0] D0 = 32'h40302010;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [3:0]  req_i;
   logic [31:0] req_data_i;
   logic [3:0]  last_i;
   logic [3:0]  gnt_o;
   logic [7:0]  fifo_wdata_o;
   logic        fifo_wr_en_o;
   logic        fifo_full_i;
   logic        busy_o;
   logic [1:0]  owner_o;

   int checks   = 0;
   int failures = 0;
   int wr_total = 0;
   int writes;

   fifo_wr_arbiter #(
      .NUM_REQ(4), .WIDTH(8), .MAX_BURST(4), .IDX_WIDTH(2), .CNT_WIDTH(2)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .req_data_i(req_data_i),
      .last_i(last_i), .gnt_o(gnt_o), .fifo_wdata_o(fifo_wdata_o),
      .fifo_wr_en_o(fifo_wr_en_o), .fifo_full_i(fifo_full_i),
      .busy_o(busy_o), .owner_o(owner_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic outs(input string tag, input logic b, input logic w,
                       input logic [3:0] g, input logic [1:0] o);
      chk({tag, ".busy"},  32'(busy_o),       32'(b));
      chk({tag, ".wr_en"}, 32'(fifo_wr_en_o), 32'(w));
      chk({tag, ".gnt"},   32'(gnt_o),        32'(g));
      chk({tag, ".owner"}, 32'(owner_o),      32'(o));
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic cyc(input logic r, input logic [3:0] q, input logic [3:0] l,
                      input logic f, input logic [31:0] d);
      @(negedge clk_i);
      rst_i = r; req_i = q; last_i = l; fifo_full_i = f; req_data_i = d;
      #1;
      if (fifo_wr_en_o === 1'b1) wr_total++;
   endtask

   initial begin
      rst_i = 1'b1; req_i = '0; last_i = '0; fifo_full_i = 1'b0; req_data_i = D0;

      // Reset with everyone requesting, then requester 0 wins first.
      cyc(1, 4'hF, 4'h0, 0, D0); outs("rst_a", 0, 0, 4'h0, 0);
      cyc(1, 4'hF, 4'h0, 0, D0); outs("rst_b", 0, 0, 4'h0, 0);
      cyc(0, 4'hF, 4'h0, 0, D0); outs("post_rst", 0, 0, 4'h0, 0);
      cyc(0, 4'hF, 4'h0, 0, D0); outs("first_gnt", 1, 1, 4'h1, 0);
      chk("first_wdata", 32'(fifo_wdata_o), 32'h10);
      cyc(0, 4'h0, 4'h0, 0, D0); outs("abandon0", 1, 0, 4'h0, 0);
      cyc(0, 4'h0, 4'h0, 0, D0); outs("idle0", 0, 0, 4'h0, 0);

      // Lone requester 1, three words ending with last.
      cyc(0, 4'h2, 4'h0, 0, 32'h40301110); outs("t2_bubble", 0, 0, 4'h0, 0);
      cyc(0, 4'h2, 4'h0, 0, 32'h40301110); outs("t2_w0", 1, 1, 4'h2, 1);
      chk("t2_d0", 32'(fifo_wdata_o), 32'h11);
      cyc(0, 4'h2, 4'h0, 0, 32'h40301210); outs("t2_w1", 1, 1, 4'h2, 1);
      chk("t2_d1", 32'(fifo_wdata_o), 32'h12);
      cyc(0, 4'h2, 4'h2, 0, 32'h40301310); outs("t2_w2", 1, 1, 4'h2, 1);
      chk("t2_d2", 32'(fifo_wdata_o), 32'h13);
      cyc(0, 4'h0, 4'h0, 0, D0); outs("t2_done", 0, 0, 4'h0, 1);

      // All four requesting: bursts of 4 with one bubble, order 0,1,2,3.
      cyc(1, 4'h0, 4'h0, 0, D0); outs("t3_rst", 0, 0, 4'h0, 0);
      writes = 0;
      for (int c = 0; c < 20; c++) begin
         cyc(0, 4'hF, 4'h0, 0, D0);
         if (fifo_wr_en_o === 1'b1) writes++;
         if (c % 5 == 0) begin
            outs($sformatf("t3_bub%0d", c), 0, 0, 4'h0, (c == 0) ? 2'd0 : 2'(c / 5 - 1));
         end else begin
            outs($sformatf("t3_c%0d", c), 1, 1, 4'(1 << (c / 5)), 2'(c / 5));
            chk($sformatf("t3_d%0d", c), 32'(fifo_wdata_o), 32'(8'h10 * (c / 5 + 1)));
         end
      end
      chk("t3_writes", 32'(writes), 32'd16);
      cyc(0, 4'hF, 4'h0, 0, D0); outs("t3_bub20", 0, 0, 4'h0, 3);
      cyc(0, 4'hF, 4'h0, 0, D0); outs("t3_wrap0", 1, 1, 4'h1, 0);
      cyc(0, 4'h0, 4'h0, 0, D0); outs("t3_drop", 1, 0, 4'h0, 0);

      // Requester 2 burst stalled by full for 3 cycles after beat 2.
      writes = wr_total;
      cyc(0, 4'h4, 4'h0, 0, 32'h40A12010); outs("t4_bubble", 0, 0, 4'h0, 0);
      cyc(0, 4'h4, 4'h0, 0, 32'h40A12010); outs("t4_b1", 1, 1, 4'h4, 2);
      chk("t4_d1", 32'(fifo_wdata_o), 32'hA1);
      cyc(0, 4'h4, 4'h0, 0, 32'h40A22010); outs("t4_b2", 1, 1, 4'h4, 2);
      chk("t4_d2", 32'(fifo_wdata_o), 32'hA2);
      cyc(0, 4'h4, 4'h0, 1, 32'h40A32010); outs("t4_full0", 1, 0, 4'h0, 2);
      cyc(0, 4'h4, 4'h4, 1, 32'h40A32010); outs("t4_full_last", 1, 0, 4'h0, 2);
      cyc(0, 4'h4, 4'h0, 1, 32'h40A32010); outs("t4_full2", 1, 0, 4'h0, 2);
      cyc(0, 4'h4, 4'h0, 0, 32'h40A32010); outs("t4_b3", 1, 1, 4'h4, 2);
      chk("t4_d3", 32'(fifo_wdata_o), 32'hA3);
      cyc(0, 4'h4, 4'h0, 0, 32'h40A42010); outs("t4_b4", 1, 1, 4'h4, 2);
      chk("t4_d4", 32'(fifo_wdata_o), 32'hA4);
      cyc(0, 4'h0, 4'h0, 0, D0); outs("t4_done", 0, 0, 4'h0, 2);
      chk("t4_writes", 32'(wr_total - writes), 32'd4);

      // Requester 3 abandons after 2 beats; requester 0 goes next.
      cyc(0, 4'h8, 4'h0, 0, D0); outs("t5_bubble", 0, 0, 4'h0, 2);
      cyc(0, 4'h8, 4'h0, 0, D0); outs("t5_b1", 1, 1, 4'h8, 3);
      chk("t5_d1", 32'(fifo_wdata_o), 32'h40);
      cyc(0, 4'h8, 4'h0, 0, D0); outs("t5_b2", 1, 1, 4'h8, 3);
      cyc(0, 4'h1, 4'h0, 0, D0); outs("t5_drop", 1, 0, 4'h0, 3);
      cyc(0, 4'h1, 4'h0, 0, D0); outs("t5_idle", 0, 0, 4'h0, 3);
      cyc(0, 4'h1, 4'h0, 0, D0); outs("t5_next0", 1, 1, 4'h1, 0);

      // Reset pulsed on beat 2 of requester 0's burst.
      cyc(1, 4'h1, 4'h0, 0, D0); outs("t6_rst", 0, 0, 4'h0, 0);
      cyc(0, 4'h0, 4'h0, 0, D0); outs("t6_after", 0, 0, 4'h0, 0);

      // Requester 3 single word, then 0 and 2 pending.
      cyc(0, 4'h8, 4'h0, 0, D0); outs("t6_bub3", 0, 0, 4'h0, 0);
      cyc(0, 4'h8, 4'h8, 0, D0); outs("t6_r3", 1, 1, 4'h8, 3);
      cyc(0, 4'h5, 4'h0, 0, D0); outs("t6_bub05", 0, 0, 4'h0, 3);
      cyc(0, 4'h5, 4'h1, 0, D0); outs("t6_r0", 1, 1, 4'h1, 0);
      chk("t6_d0", 32'(fifo_wdata_o), 32'h10);
      cyc(0, 4'h5, 4'h0, 0, D0); outs("t6_bub_prio", 0, 0, 4'h0, 0);
`ifdef FIFO_ARB_PRIO_EN
      cyc(0, 4'h5, 4'hF, 0, D0); outs("t6_prio", 1, 1, 4'h1, 0);
      chk("t6_prio_d", 32'(fifo_wdata_o), 32'h10);
      cyc(0, 4'h0, 4'h0, 0, D0); outs("t6_end", 0, 0, 4'h0, 0);
`else
      cyc(0, 4'h5, 4'hF, 0, D0); outs("t6_rr", 1, 1, 4'h4, 2);
      chk("t6_rr_d", 32'(fifo_wdata_o), 32'h30);
      cyc(0, 4'h0, 4'h0, 0, D0); outs("t6_end", 0, 0, 4'h0, 2);
`endif

      chk("total_writes", 32'(wr_total), 32'd31);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
